nios_system_onchip_mem_arbiter: RTL
===================================

NIOS_SYSTEM_ONCHIP_MEM_ARBITER -- requirements
Module: nios_system_onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: word address width on every port.
REQ-002 Parameter DEPTH, default 5120: number of implemented memory words.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mN_address  input  ADDR_W  word address from requester N (N = 0, 1; each mN_* line defines one port per requester).
REQ-006 mN_read  input  1  read request.
REQ-007 mN_write  input  1  write request.
REQ-008 mN_byteenable  input  4  write byte lanes.
REQ-009 mN_writedata  input  32  write data.
REQ-010 mN_waitrequest  output  1  request not accepted this cycle.
REQ-011 mN_readdata  output  32  read data.
REQ-012 mN_readdatavalid  output  1  qualifies mN_readdata.
REQ-013 mem_address  output  ADDR_W  memory address.
REQ-014 mem_byteenable  output  4  memory byte lanes.
REQ-015 mem_chipselect  output  1  memory access this cycle.
REQ-016 mem_write  output  1  memory write strobe.
REQ-017 mem_writedata  output  32  memory write data.
REQ-018 mem_readdata  input  32  memory q, valid one cycle after a read access.
REQ-019 mem_clken  output  1  memory clock enable.
REQ-020 err_oob  output  1  out-of-range access pulse.

Function
REQ-021 mN_req = mN_read | mN_write; if both are high, the access SHALL be treated as a write.
REQ-022 Grant SHALL be combinational each cycle: sole requester is granted; on a tie, the requester not granted most recently wins.
REQ-023 last_grant register SHALL update to the granted index on every grant and hold otherwise.
REQ-024 mN_waitrequest SHALL equal mN_req & ~grantN; an idle requester sees 0.
REQ-025 On a grant: mem_chipselect=1; mem_address/byteenable/writedata muxed from the winner; mem_write = winner's write.
REQ-026 No grant: mem_chipselect=0, mem_write=0, mem_address=0, mem_byteenable=0, mem_writedata=0.
REQ-027 mem_clken SHALL be 1 whenever reset is low, 0 while reset is high.
REQ-028 Accepted read SHALL set rd_pend (valid, owner); next cycle owner's readdatavalid=1, fixed latency 1.
REQ-029 mem_readdata SHALL drive both mN_readdata unregistered; only the owner's readdatavalid asserts.
REQ-030 Back-to-back reads (same or alternating requesters) SHALL be accepted every cycle with no bubble.
REQ-031 Writes complete on acceptance; no response is generated.
REQ-032 Under continuous contention each requester SHALL wait at most 1 cycle.

Reset
REQ-033 Reset values: last_grant=1 (m0 wins first tie), rd_pend=0, both readdatavalid=0, err_oob=0.
REQ-034 While reset is high: no grant, waitrequest = mN_req, mem_chipselect=0.
REQ-035 A read accepted in the cycle before reset asserts SHALL be dropped; no readdatavalid after release.

Configuration
REQ-036 ONCHIP_MEM_ARB_BOUNDS_CHECK_EN defined: a granted access with address >= DEPTH is accepted, mem_chipselect=0, write dropped, read returns readdatavalid after 1 cycle with readdata 0, err_oob=1 for exactly that one cycle.
REQ-037 Macro undefined: address forwarded unchanged regardless of DEPTH; err_oob tied 0.

Verification
REQ-038 m0 read addr 0x10 alone -> mem_chipselect=1, m0_waitrequest=0; next cycle m0_readdatavalid=1, m0_readdata = mem_readdata.
REQ-039 Both write every cycle from reset release -> grants m0,m1,m0,m1; each waitrequest high on alternate cycles only.
REQ-040 m0 write 0xA5A5A5A5 be=0x3 to 0x20, then m1 read 0x20 -> mem_write=1 with be=0x3, then m1_readdatavalid only (m0_readdatavalid=0).
REQ-041 Reset asserted the cycle after an accepted m1 read -> m1_readdatavalid never asserts; first tie after release grants m0.
REQ-042 Macro defined, m0 read 0x1400 (5120) -> mem_chipselect=0, next cycle m0_readdatavalid=1, readdata 0x00000000, err_oob=1 for one cycle.

Source files
------------

// File: rtl/nios_system_onchip_mem_arbiter.sv
// rtl/nios_system_onchip_mem_arbiter.sv - two-requester arbiter in front of a single-port on-chip RAM.
// Optional address bounds checking is enabled by defining ONCHIP_MEM_ARB_BOUNDS_CHECK_EN.
module nios_system_onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [3:0]        m0_byteenable,
  input  logic [31:0]       m0_writedata,
  output logic              m0_waitrequest,
  output logic [31:0]       m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [3:0]        m1_byteenable,
  input  logic [31:0]       m1_writedata,
  output logic              m1_waitrequest,
  output logic [31:0]       m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              mem_clken,

  output logic              err_oob
);

  logic              req0;
  logic              req1;
  logic              grant0;
  logic              grant1;
  logic              granted;
  logic              win_write;
  logic [ADDR_W-1:0] win_addr;
  logic [3:0]        win_be;
  logic [31:0]       win_wdata;
  logic              oob;

  logic last_grant_q, last_grant_d;
  logic rd_valid_q,   rd_valid_d;
  logic rd_owner_q,   rd_owner_d;
  logic rd_oob_q,     rd_oob_d;
  logic err_oob_q,    err_oob_d;

  // Grant: sole requester wins; on a tie the one not served last time wins.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0 && (!req1 || last_grant_q)) begin
        grant0 = 1'b1;
      end else if (req1) begin
        grant1 = 1'b1;
      end
    end
    granted = grant0 | grant1;
  end

  always_comb begin
    win_write = grant1 ? m1_write      : m0_write;
    win_addr  = grant1 ? m1_address    : m0_address;
    win_be    = grant1 ? m1_byteenable : m0_byteenable;
    win_wdata = grant1 ? m1_writedata  : m0_writedata;
  end

`ifdef ONCHIP_MEM_ARB_BOUNDS_CHECK_EN
  always_comb begin
    oob = granted && (32'(win_addr) >= 32'(DEPTH));
  end
`else
  always_comb begin
    oob = 1'b0;
  end
`endif

  // Out-of-range accesses are still accepted but never reach the RAM.
  always_comb begin
    mem_chipselect = granted & ~oob;
    mem_write      = granted & win_write & ~oob;
    mem_address    = granted ? win_addr  : '0;
    mem_byteenable = granted ? win_be    : 4'h0;
    mem_writedata  = granted ? win_wdata : 32'h0;
    mem_clken      = ~reset;
    m0_waitrequest = req0 & ~grant0;
    m1_waitrequest = req1 & ~grant1;
  end

  always_comb begin
    last_grant_d = granted ? grant1 : last_grant_q;
    rd_valid_d   = granted & ~win_write;
    rd_owner_d   = grant1;
    rd_oob_d     = oob;
    err_oob_d    = oob;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oob_q     <= 1'b0;
      err_oob_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
      rd_oob_q     <= rd_oob_d;
      err_oob_q    <= err_oob_d;
    end
  end

  always_comb begin
    m0_readdata      = rd_oob_q ? 32'h0 : mem_readdata;
    m1_readdata      = rd_oob_q ? 32'h0 : mem_readdata;
    m0_readdatavalid = rd_valid_q & ~rd_owner_q;
    m1_readdatavalid = rd_valid_q &  rd_owner_q;
    err_oob          = err_oob_q;
  end

endmodule
